// File: rtl/telemetry_frame_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mppc_pkg
// Description : Shared types and constants for the telemetry frame scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package mppc_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SNAP    = 3'd1,
        LOAD    = 3'd2,
        WAIT_HI = 3'd3,
        WAIT_LO = 3'd4
    } state_t;

    localparam logic [7:0] SYNC0 = 8'hA5;
    localparam logic [7:0] SYNC1 = 8'h5A;

    // Two sync bytes, sequence number and checksum around the counter payload.
    function automatic int frame_len(input int num_ch);
        return 2 * num_ch + 4;
    endfunction

endpackage
`default_nettype wire

// File: rtl/telemetry_frame_scheduler_frame_byte_mux.sv
`default_nettype none
// ============================================================================
// Module      : frame_byte_mux
// Description : Selects the frame byte at a given index from header, sequence
//               number, snapshot payload and running checksum.
// Revision    : 1.0 - initial release
// ============================================================================
module frame_byte_mux
    import mppc_pkg::*;
#(
    parameter int NUM_CH = 8,
    parameter int CNT_W  = 16,
    parameter int IDX_W  = 5
) (
    input  logic [IDX_W-1:0]        i_idx,
    input  logic [7:0]              i_seq_num,
    input  logic [NUM_CH*CNT_W-1:0] i_snapshot,
    input  logic [7:0]              i_checksum,
    output logic [7:0]              o_byte
);

    localparam int c_frame_len = frame_len(NUM_CH);

    logic [7:0] w_frame [2**IDX_W];

    // Table covers the full index range so unused slots read as zero.
    for (genvar gi = 0; gi < 2**IDX_W; gi++) begin : g_byte
        if (gi == 0) begin : g_sync0
            assign w_frame[gi] = SYNC0;
        end else if (gi == 1) begin : g_sync1
            assign w_frame[gi] = SYNC1;
        end else if (gi == 2) begin : g_seq
            assign w_frame[gi] = i_seq_num;
        end else if (gi < c_frame_len - 1) begin : g_payload
            assign w_frame[gi] = i_snapshot[(gi-3)*8 +: 8];
        end else if (gi == c_frame_len - 1) begin : g_csum
            assign w_frame[gi] = i_checksum;
        end else begin : g_unused
            assign w_frame[gi] = 8'h00;
        end
    end

    assign o_byte = w_frame[i_idx];

endmodule
`default_nettype wire

// File: rtl/telemetry_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : telemetry_frame_scheduler
// Description : Periodically snapshots the event counters and streams one
//               framed, checksummed packet through the shared uart_tx.
// Revision    : 1.0 - initial release
// ============================================================================
module telemetry_frame_scheduler
    import mppc_pkg::*;
#(
    parameter int PERIOD = 500000,
    parameter int NUM_CH = 8,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_CH*CNT_W-1:0] counts_in,
    input  logic                    force_frame,
    input  logic                    tx_busy,
    output logic                    tx_send,
    output logic [7:0]              tx_data,
    output logic                    cnt_clear,
    output logic                    frame_active,
    output logic [7:0]              seq_num,
    output logic                    overrun
);

    localparam int c_frame_len = frame_len(NUM_CH);
    localparam int c_idx_w     = $clog2(c_frame_len);
    localparam int c_tmr_w     = $clog2(PERIOD);
    localparam logic [c_idx_w-1:0] c_last_idx  = c_idx_w'(c_frame_len - 1);
    localparam logic [c_idx_w-1:0] c_first_sum = c_idx_w'(2);
    localparam logic [c_tmr_w-1:0] c_tmr_max   = c_tmr_w'(PERIOD - 1);

    state_t                    r_state;
    logic [c_tmr_w-1:0]        r_timer;
    logic                      r_pending;
    logic                      r_overrun;
    logic [c_idx_w-1:0]        r_idx;
    logic [NUM_CH*CNT_W-1:0]   r_snapshot;
    logic [7:0]                r_checksum;
    logic                      r_tx_send;
    logic [7:0]                r_tx_data;
    logic                      r_cnt_clear;
    logic                      r_frame_active;
    logic [7:0]                r_seq_num;

    logic                      w_tick;
    logic                      w_trigger;
    logic                      w_last;
    logic                      w_in_sum;
    logic [7:0]                w_byte;

    assign w_tick    = (r_timer == c_tmr_max);
    assign w_trigger = w_tick | force_frame;
    assign w_last    = (r_idx == c_last_idx);
    assign w_in_sum  = (r_idx >= c_first_sum) && (r_idx < c_last_idx);

    frame_byte_mux #(
        .NUM_CH (NUM_CH),
        .CNT_W  (CNT_W),
        .IDX_W  (c_idx_w)
    ) u_byte_mux (
        .i_idx      (r_idx),
        .i_seq_num  (r_seq_num),
        .i_snapshot (r_snapshot),
        .i_checksum (r_checksum),
        .o_byte     (w_byte)
    );

    always_ff @(posedge clk) begin
        if (reset || w_tick) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + c_tmr_w'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= IDLE;
            r_pending      <= 1'b0;
            r_overrun      <= 1'b0;
            r_idx          <= '0;
            r_snapshot     <= '0;
            r_checksum     <= '0;
            r_tx_send      <= 1'b0;
            r_tx_data      <= '0;
            r_cnt_clear    <= 1'b0;
            r_frame_active <= 1'b0;
            r_seq_num      <= 8'hFF;
        end else begin
            r_tx_send   <= 1'b0;
            r_cnt_clear <= 1'b0;

            // One-deep request queue; a second request while one waits is lost.
            if (w_trigger && r_pending) begin
                r_overrun <= 1'b1;
            end else if (w_trigger && (r_state != IDLE)) begin
                r_pending <= 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if (w_trigger || r_pending) begin
                        r_state        <= SNAP;
                        r_frame_active <= 1'b1;
                    end
                end
                SNAP: begin
                    r_snapshot  <= counts_in;
                    r_cnt_clear <= 1'b1;
                    r_seq_num   <= r_seq_num + 8'd1;
                    r_pending   <= w_trigger && !r_pending;
                    r_checksum  <= '0;
                    r_idx       <= '0;
                    r_state     <= LOAD;
                end
                LOAD: begin
                    if (!tx_busy) begin
                        r_tx_send <= 1'b1;
                        r_tx_data <= w_byte;
                        if (w_in_sum) begin
                            r_checksum <= r_checksum + w_byte;
                        end
                        r_state <= WAIT_HI;
                    end
                end
                WAIT_HI: begin
                    if (tx_busy) begin
                        r_state <= WAIT_LO;
                    end
                end
                WAIT_LO: begin
                    if (!tx_busy) begin
                        if (w_last) begin
                            r_state        <= IDLE;
                            r_frame_active <= 1'b0;
                        end else begin
                            r_idx   <= r_idx + c_idx_w'(1);
                            r_state <= LOAD;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign tx_send      = r_tx_send;
    assign tx_data      = r_tx_data;
    assign cnt_clear    = r_cnt_clear;
    assign frame_active = r_frame_active;
    assign seq_num      = r_seq_num;
    assign overrun      = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_telemetry_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_telemetry_frame_scheduler
// Description : Directed self-checking bench with a busy-stretchable uart_tx model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_telemetry_frame_scheduler;

    localparam int PERIOD    = 2000;
    localparam int NUM_CH    = 8;
    localparam int CNT_W     = 16;
    localparam int FRAME_LEN = 20;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [NUM_CH*CNT_W-1:0] counts_in;
    logic                    force_frame;
    logic                    tx_busy = 1'b0;
    logic                    tx_send;
    logic [7:0]              tx_data;
    logic                    cnt_clear;
    logic                    frame_active;
    logic [7:0]              seq_num;
    logic                    overrun;

    always #5 clk = ~clk;

    telemetry_frame_scheduler #(
        .PERIOD (PERIOD),
        .NUM_CH (NUM_CH),
        .CNT_W  (CNT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .counts_in    (counts_in),
        .force_frame  (force_frame),
        .tx_busy      (tx_busy),
        .tx_send      (tx_send),
        .tx_data      (tx_data),
        .cnt_clear    (cnt_clear),
        .frame_active (frame_active),
        .seq_num      (seq_num),
        .overrun      (overrun)
    );

    // uart_tx stand-in: 10 bits x 4 clocks by default, stretchable per test.
    int busy_len = 40;
    int bcnt     = 0;
    always @(posedge clk) begin
        if (reset) begin
            tx_busy <= 1'b0;
            bcnt    <= 0;
        end else if (tx_busy) begin
            if (bcnt <= 1) tx_busy <= 1'b0;
            else           bcnt    <= bcnt - 1;
        end else if (tx_send) begin
            tx_busy <= 1'b1;
            bcnt    <= busy_len;
        end
    end

    int         n_checks = 0;
    int         n_err    = 0;
    int         cyc      = 0;
    int         n_clear  = 0;
    int         n_fall   = 0;
    int         n_done   = 0;
    int         rise_cyc = 0;
    int         fall_cyc = 0;
    int         f1_fall  = 0;
    logic       fa_prev  = 1'b0;
    logic       mutate   = 1'b0;
    logic [127:0] snap   = '0;
    logic [7:0] q [$];
    logic [7:0] exp_seq  = 8'h00;

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock; observe outputs 1 time unit after the edge, then drive.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (mutate) counts_in = {$urandom(), $urandom(), $urandom(), $urandom()};
        if (tx_send === 1'b1) q.push_back(tx_data);
        if (cnt_clear === 1'b1) n_clear++;
        if (frame_active === 1'b1 && !fa_prev) begin
            rise_cyc = cyc;
            snap     = counts_in;
            q.delete();
        end
        if (frame_active !== 1'b1 && fa_prev) begin
            n_fall++;
            fall_cyc = cyc;
        end
        fa_prev = (frame_active === 1'b1);
    endtask

    function automatic logic [159:0] exp_frame(input logic [7:0] s, input logic [127:0] c);
        logic [159:0] f;
        logic [7:0]   cs;
        f        = '0;
        f[7:0]   = 8'hA5;
        f[15:8]  = 8'h5A;
        f[23:16] = s;
        cs       = s;
        for (int k = 0; k < 2*NUM_CH; k++) begin
            f[8*(3+k) +: 8] = c[8*k +: 8];
            cs = cs + c[8*k +: 8];
        end
        f[159:152] = cs;
        return f;
    endfunction

    task automatic capture_frame(input string tag, input int budget);
        int           n;
        logic [159:0] obs;
        n = 0;
        while (n_fall == n_done && n < budget) begin
            step();
            n++;
        end
        chk({tag, "_timeout"}, (n_fall == n_done), 0);
        n_done = n_fall;
        obs = '0;
        for (int i = 0; i < FRAME_LEN; i++)
            if (i < q.size()) obs[8*i +: 8] = q[i];
        chk({tag, "_len"}, q.size(), FRAME_LEN);
        chk({tag, "_frame"}, obs, exp_frame(exp_seq, snap));
        exp_seq = exp_seq + 8'd1;
    endtask

    task automatic reset_dut(input string tag);
        reset       = 1'b1;
        force_frame = 1'b0;
        step();
        chk({tag, "_tx_send"}, tx_send, 0);
        chk({tag, "_tx_data"}, tx_data, 0);
        chk({tag, "_cnt_clear"}, cnt_clear, 0);
        chk({tag, "_frame_active"}, frame_active, 0);
        chk({tag, "_seq_num"}, seq_num, 8'hFF);
        chk({tag, "_overrun"}, overrun, 0);
        step();
        reset   = 1'b0;
        cyc     = 0;
        n_clear = 0;
        n_fall  = 0;
        n_done  = 0;
        exp_seq = 8'h00;
        q.delete();
    endtask

    task automatic pulse_force();
        force_frame = 1'b1;
        step();
        force_frame = 1'b0;
    endtask

    initial begin
        int n;
        reset       = 1'b1;
        force_frame = 1'b0;
        counts_in   = '0;

        reset_dut("rst");

        // T1: periodic frame with known counter pattern
        for (int i = 0; i < NUM_CH; i++) counts_in[16*i +: 16] = 16'(16'h0102 * (i + 1));
        capture_frame("t1", 3000);
        chk("t1_start_cycle", rise_cyc, PERIOD);
        chk("t1_byte3", q[3], 8'h02);
        chk("t1_byte4", q[4], 8'h01);
        chk("t1_byte17", q[17], 8'h10);
        chk("t1_byte18", q[18], 8'h08);
        chk("t1_checksum", q[19], 8'h6C);
        chk("t1_cnt_clear", n_clear, 1);
        chk("t1_seq_num", seq_num, 8'h00);

        // T2: forced frame shortly after reset, then the periodic one
        reset_dut("t2_rst");
        for (int i = 0; i < NUM_CH; i++) counts_in[16*i +: 16] = 16'(16'h1111 * i + 16'h0F0F);
        for (int i = 0; i < 9; i++) step();
        pulse_force();
        capture_frame("t2_forced", 2000);
        chk("t2_force_latency", (rise_cyc >= 10 && rise_cyc <= 13), 1);
        capture_frame("t2_tick", 3000);
        chk("t2_tick_start", rise_cyc, PERIOD);
        chk("t2_seq_num", seq_num, 8'h01);

        // T4: counters churn every cycle around and during the frame
        mutate = 1'b1;
        pulse_force();
        capture_frame("t4", 2000);
        mutate = 1'b0;

        // T3: slow transmitter forces pending restart and overrun
        reset_dut("t3_rst");
        busy_len = 222;
        capture_frame("t3_f1", 8000);
        f1_fall = fall_cyc;
        chk("t3_f1_duration", (f1_fall - PERIOD >= 4400 && f1_fall - PERIOD <= 4600), 1);
        chk("t3_overrun", overrun, 1);
        step();
        chk("t3_restart", frame_active, 1);
        chk("t3_restart_gap", rise_cyc - f1_fall, 1);
        capture_frame("t3_f2", 6000);
        chk("t3_cnt_clear", n_clear, 2);
        busy_len = 40;

        // T5: reset during byte 7
        reset_dut("t5_pre");
        for (int i = 0; i < 4; i++) step();
        pulse_force();
        n = 0;
        while (q.size() < 8 && n < 2000) begin
            step();
            n++;
        end
        chk("t5_reach_byte7", (q.size() >= 8), 1);
        reset_dut("t5_abort");
        pulse_force();
        capture_frame("t5_after", 2000);

        // T6: sequence wrap with fast transmitter
        busy_len = 1;
        for (int k = 0; k < 256; k++) begin
            counts_in = {$urandom(), $urandom(), $urandom(), $urandom()};
            if (frame_active !== 1'b1) pulse_force();
            capture_frame("t6", 400);
        end
        chk("t6_seq_wrap", seq_num, 8'h00);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
